reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
Tracks in-flight destination-register writes for the pipelined core, one pending counter per architectural register. It is the producer-side counterpart of the 3-bit register-index comparators used by decode for hazard checks. Decode presents source indices and receives a stall decision. Issue records a new pending write, and writeback retires it.

Parameters:
NUM_REGS, 8, number of architectural registers (must equal 2**REG_W).
REG_W, 3, register index width.
MAX_PEND, 3, maximum outstanding writes per register.
CNT_W, 2, per-register counter width (must satisfy 2**CNT_W > MAX_PEND).

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  asynchronous active-low reset.
rs  in  REG_W  decode source register A index.
rs_valid  in  1  rs is actually read by the instruction.
rt  in  REG_W  decode source register B index.
rt_valid  in  1  rt is actually read by the instruction.
issue_valid  in  1  decode wants to issue an instruction this cycle.
issue_wr  in  1  issuing instruction writes a register.
issue_rd  in  REG_W  destination index of issuing instruction.
ret_valid  in  1  writeback retires one register write this cycle.
ret_rd  in  REG_W  destination index being retired.
flush  in  1  pipeline flush; discard all pending state.
stall  out  1  combinational; issue is blocked this cycle.
busy  out  NUM_REGS  bit i = (count[i] != 0).
err  out  1  sticky; a retire arrived for a register with count 0.

Behaviour:
- State: count[0..NUM_REGS-1] (CNT_W bits each) and err.
- Reset (rst=0, async): all counts = 0, err = 0. Consequently busy = 0 and stall = 0.
- stall asserts (combinational, from registered counts only; no same-cycle retire bypass) when any of:
  - rs_valid & count[rs] != 0
  - rt_valid & count[rt] != 0
  - issue_valid & issue_wr & count[issue_rd] == MAX_PEND
- stall is independent of issue_valid for the source checks. Decode ANDs it.
- Issue accepted = issue_valid & issue_wr & !stall & !flush.
- Retire effective = ret_valid & !flush & count[ret_rd] != 0.
- Per-register next count, by priority:
  1. flush: all counts <- 0, regardless of issue or retire.
  2. Accepted issue and effective retire to the same register: count unchanged.
  3. Accepted issue: count[issue_rd] + 1.
  4. Effective retire: count[ret_rd] - 1.
  5. Issue and retire to different registers: both updates apply in the same cycle.
- Counters never wrap. Overflow is prevented by stall. On underflow (ret_valid & !flush & count[ret_rd] == 0) the count holds at 0 and err <- 1.
- err clears only on reset. flush does not clear err.
- issue_valid & !issue_wr: no state change. Source stall still applies.
- Index 0 is tracked like any other register; no special casing.
- Latency: an accepted issue is visible in busy and stall on the next cycle. A retire clears on the next cycle.
- Reset asserted mid-operation: all state clears immediately. The first edge after deassertion behaves as from reset.

Test Plan:
1. Reset, then rs=3, rs_valid=1, rt_valid=0 → stall=0, busy=8'h00, err=0.
2. Issue wr to rd=5. Next cycle rs=5, rs_valid=1 → stall=1, busy=8'h20. Retire rd=5. Next cycle → stall=0, busy=8'h00.
3. Issue rd=2 three times (rs_valid=rt_valid=0). Fourth issue to rd=2 → stall=1, count stays 3. Retire once. Next issue accepted, count back to 3.
4. count[4]=1; same cycle accepted issue rd=4 and retire rd=4 → count[4] stays 1, busy[4]=1. Issue rd=1 plus retire rd=4 → busy=8'h02.
5. Pending on rd=1,6; assert flush together with issue rd=3 and retire rd=1 → next cycle busy=8'h00, err unchanged.
6. Retire rd=7 with count 0 → err=1 and stays 1 after flush. Only rst=0 returns err=0. Pulse rst low mid-sequence with counts nonzero → busy=0 before the next clk edge.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Decode/issue/writeback signal bundle for the register scoreboard.
// The scoreboard side uses the slave modport and the pipeline side uses the master modport.
interface reg_scoreboard_if #(
  parameter int REG_W    = 3,
  parameter int NUM_REGS = 8
);
  // Handshake: an issue request (issue_valid & issue_wr) is taken on the rising edge
  // only while stall is low and flush is low. A retire (ret_valid) is not
  // back-pressured and completes on the edge where it is presented.
  logic [REG_W-1:0]    rs;
  logic                rs_valid;
  logic [REG_W-1:0]    rt;
  logic                rt_valid;
  logic                issue_valid;
  logic                issue_wr;
  logic [REG_W-1:0]    issue_rd;
  logic                ret_valid;
  logic [REG_W-1:0]    ret_rd;
  logic                flush;
  logic                stall;
  logic [NUM_REGS-1:0] busy;
  logic                err;

  modport master (
    output rs, rs_valid, rt, rt_valid, issue_valid, issue_wr, issue_rd,
           ret_valid, ret_rd, flush,
    input  stall, busy, err
  );

  modport slave (
    input  rs, rs_valid, rt, rt_valid, issue_valid, issue_wr, issue_rd,
           ret_valid, ret_rd, flush,
    output stall, busy, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters. Decode gets a stall when a source is still
// being produced or when its destination already has MAX_PEND writes in flight.
module reg_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  reg_scoreboard_if.slave   sb
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);

  logic [CNT_W-1:0] count     [NUM_REGS];
  logic [CNT_W-1:0] count_nxt [NUM_REGS];
  logic             err_q;
  logic             err_nxt;
  logic             issue_acc;
  logic             ret_eff;
  logic             stall_int;

  // Stall looks only at registered counts; a retire this cycle does not release it.
  assign stall_int = (sb.rs_valid && (count[sb.rs] != '0)) ||
                     (sb.rt_valid && (count[sb.rt] != '0)) ||
                     (sb.issue_valid && sb.issue_wr && (count[sb.issue_rd] == MAX_CNT));

  assign issue_acc = sb.issue_valid && sb.issue_wr && !stall_int && !sb.flush;
  assign ret_eff   = sb.ret_valid && !sb.flush && (count[sb.ret_rd] != '0);

  assign sb.stall = stall_int;
  assign sb.err   = err_q;

  always_comb begin
    err_nxt = err_q || (sb.ret_valid && !sb.flush && (count[sb.ret_rd] == '0));
    for (int i = 0; i < NUM_REGS; i++) begin
      count_nxt[i] = count[i];
      if (sb.flush) begin
        count_nxt[i] = '0;
      end else begin
        // Issue and retire to the same register cancel out.
        if (issue_acc && (sb.issue_rd == REG_W'(i)) &&
            !(ret_eff && (sb.ret_rd == REG_W'(i)))) begin
          count_nxt[i] = count[i] + 1'b1;
        end else if (ret_eff && (sb.ret_rd == REG_W'(i)) &&
                     !(issue_acc && (sb.issue_rd == REG_W'(i)))) begin
          count_nxt[i] = count[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    sb.busy = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sb.busy[i] = (count[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        count[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      count <= count_nxt;
      err_q <= err_nxt;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Vector-table bench for reg_scoreboard with an expected-result queue for the
// registered outputs and a hand-written asynchronous reset sequence.
module tb_reg_scoreboard;
  typedef struct {
    logic [2:0] rs;
    logic       rs_valid;
    logic [2:0] rt;
    logic       rt_valid;
    logic       issue_valid;
    logic       issue_wr;
    logic [2:0] issue_rd;
    logic       ret_valid;
    logic [2:0] ret_rd;
    logic       flush;
    logic       exp_stall;
    logic [7:0] exp_busy;
    logic       exp_err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [8:0] exp_q[$];
  vec_t tbl[$];

  reg_scoreboard_if #(.REG_W(3), .NUM_REGS(8)) sbi ();

  reg_scoreboard dut (
    .clk (clk),
    .rst (rst_n),
    .sb  (sbi)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input int rs, input int rsv, input int rt, input int rtv,
    input int iv, input int iw, input int ird, input int rv, input int rrd,
    input int fl, input int stall, input int busy, input int err);
    vec_t v;
    v.rs = 3'(rs);   v.rs_valid = 1'(rsv);
    v.rt = 3'(rt);   v.rt_valid = 1'(rtv);
    v.issue_valid = 1'(iv); v.issue_wr = 1'(iw); v.issue_rd = 3'(ird);
    v.ret_valid = 1'(rv);   v.ret_rd = 3'(rrd);  v.flush = 1'(fl);
    v.exp_stall = 1'(stall); v.exp_busy = 8'(busy); v.exp_err = 1'(err);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sbi.rs = v.rs;             sbi.rs_valid = v.rs_valid;
    sbi.rt = v.rt;             sbi.rt_valid = v.rt_valid;
    sbi.issue_valid = v.issue_valid; sbi.issue_wr = v.issue_wr;
    sbi.issue_rd = v.issue_rd; sbi.ret_valid = v.ret_valid;
    sbi.ret_rd = v.ret_rd;     sbi.flush = v.flush;
  endtask

  // Driver: stall is checked combinationally, busy/err are queued for after the edge.
  task automatic apply(input vec_t v, input int idx);
    logic [8:0] exp;
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("stall[%0d]", idx), 32'(sbi.stall), 32'(v.exp_stall));
    exp_q.push_back({v.exp_busy, v.exp_err});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL queue[%0d]: got empty, expected entry", idx);
    end else begin
      exp = exp_q.pop_front();
      chk($sformatf("busy[%0d]", idx), 32'(sbi.busy), 32'(exp[8:1]));
      chk($sformatf("err[%0d]", idx), 32'(sbi.err), 32'(exp[0]));
    end
  endtask

  initial begin
    vec_t idle;
    tests = 0;
    fails = 0;
    idle = mk(0,0,0,0, 0,0,0, 0,0, 0, 0,8'h00,0);
    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(sbi.busy), 32'h0);
    chk("reset_err", 32'(sbi.err), 32'h0);
    chk("reset_stall", 32'(sbi.stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //          rs v rt v iv iw ird rv rrd fl  stall busy  err
    tbl.push_back(mk(3,1, 0,0, 0,0,0, 0,0, 0,  0, 8'h00, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,5, 0,0, 0,  0, 8'h20, 0));
    tbl.push_back(mk(5,1, 0,0, 0,0,0, 0,0, 0,  1, 8'h20, 0));
    tbl.push_back(mk(5,1, 0,0, 0,0,0, 1,5, 0,  1, 8'h00, 0));
    tbl.push_back(mk(5,1, 0,0, 0,0,0, 0,0, 0,  0, 8'h00, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,2, 0,0, 0,  0, 8'h04, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,2, 0,0, 0,  0, 8'h04, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,2, 0,0, 0,  0, 8'h04, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,2, 0,0, 0,  1, 8'h04, 0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 1,2, 0,  0, 8'h04, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,2, 0,0, 0,  0, 8'h04, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,2, 0,0, 0,  1, 8'h04, 0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 1,2, 0,  0, 8'h04, 0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 1,2, 0,  0, 8'h04, 0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 1,2, 0,  0, 8'h00, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,4, 0,0, 0,  0, 8'h10, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,4, 1,4, 0,  0, 8'h10, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,1, 1,4, 0,  0, 8'h02, 0));
    tbl.push_back(mk(0,0, 1,1, 1,0,3, 0,0, 0,  1, 8'h02, 0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 1,1, 0,  0, 8'h00, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,0, 0,0, 0,  0, 8'h01, 0));
    tbl.push_back(mk(0,1, 0,0, 0,0,0, 0,0, 0,  1, 8'h01, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,1, 1,0, 0,  0, 8'h02, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,6, 0,0, 0,  0, 8'h42, 0));
    tbl.push_back(mk(0,0, 0,0, 1,1,3, 1,1, 1,  0, 8'h00, 0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 1,0, 1,  0, 8'h00, 0));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 1,7, 0,  0, 8'h00, 1));
    tbl.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 1,  0, 8'h00, 1));
    tbl.push_back(mk(0,0, 0,0, 1,1,6, 0,0, 0,  0, 8'h40, 1));
    tbl.push_back(mk(0,0, 6,1, 0,0,0, 0,0, 0,  1, 8'h40, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Asynchronous reset with rd=6 still pending: outputs clear before any edge.
    @(negedge clk);
    drive(mk(0,0, 6,1, 0,0,0, 0,0, 0, 0,8'h00,0));
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(sbi.busy), 32'h0);
    chk("async_err", 32'(sbi.err), 32'h0);
    chk("async_stall", 32'(sbi.stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release behaves as from reset: retire of rd=6 underflows.
    apply(mk(0,0, 0,0, 0,0,0, 1,6, 0,  0, 8'h00, 1), 100);
    apply(mk(0,0, 0,0, 1,1,6, 0,0, 0,  0, 8'h40, 1), 101);
    apply(mk(6,1, 0,0, 1,1,6, 0,0, 0,  1, 8'h40, 1), 102);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("final_reset_err", 32'(sbi.err), 32'h0);
    chk("final_reset_busy", 32'(sbi.busy), 32'h0);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
